// File: rtl/gf_col_pkg.sv
// gf_col_pkg: shared state type, GF(2^M) alpha-power helper and beat-count constants
//   Macro GF_COL_PARITY_EN (see top) adds a per-lane parity output.
package gf_col_pkg;

    typedef enum logic {IDLE, RUN} state_e;

    localparam int DEF_M     = 13;
    localparam int DEF_N     = 16;
    localparam int DEF_LANES = 4;

    // x * alpha^e in GF(2^m), where alpha^m = poly (low terms of the primitive polynomial).
    // Only used on constants, so it folds away into a fixed XOR network.
    function automatic logic [31:0] gf_mul_alpha_pow(input logic [31:0] x, input int e,
                                                     input int m, input logic [31:0] poly);
        logic [31:0] r;
        logic [31:0] mask;
        r    = x;
        mask = (32'h1 << m) - 32'h1;
        for (int i = 0; i < e; i++)
            r = r[m-1] ? (((r << 1) & mask) ^ poly) : ((r << 1) & mask);
        return r;
    endfunction

    function automatic int nbeats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int beat_w(input int n, input int lanes);
        return $clog2(nbeats(n, lanes)) + 1;
    endfunction

endpackage

// File: rtl/gf_const_alpha_mult.sv
// gf_const_alpha_mult: combinational y = x * alpha^E in GF(2^M)
//   x  in  M  field element
//   y  out M  product
module gf_const_alpha_mult
    import gf_col_pkg::*;
#(
    parameter int           M    = 13,
    parameter logic [M-1:0] POLY = 13'h001B,
    parameter int           E    = 1
) (
    input  logic [M-1:0] x,
    output logic [M-1:0] y
);

    logic [M-1:0] terms [M];

    // Column i of the constant matrix is alpha^i * alpha^E.
    for (genvar i = 0; i < M; i++) begin : g_col
        localparam logic [M-1:0] C = M'(gf_mul_alpha_pow(32'h1 << i, E, M, 32'(POLY)));
        assign terms[i] = x[i] ? C : '0;
    end

    always_comb begin
        y = '0;
        for (int i = 0; i < M; i++)
            y ^= terms[i];
    end

endmodule

// File: rtl/gf_alpha_column_seq.sv
// gf_alpha_column_seq: streams b*alpha^(k*STRIDE), k=1..N, LANES products per beat
//   clk, rst (async, active high)
//   in_valid/in_ready/in_b            : element input, accepted only while idle
//   out_valid/out_ready               : beat handshake
//   out_data [LANES*M]                : lane j at [j*M +: M]
//   out_mask [LANES]                  : lane holds a real product (k <= N)
//   out_beat, out_last                : beat index and final-beat flag
//   out_parity [LANES]                : only with GF_COL_PARITY_EN, XOR reduction per lane
//   busy                              : element in flight
module gf_alpha_column_seq
    import gf_col_pkg::*;
#(
    parameter int           M      = 13,
    parameter logic [M-1:0] POLY   = 13'h001B,
    parameter int           N      = 16,
    parameter int           LANES  = 4,
    parameter int           STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [M-1:0]                 in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*M-1:0]           out_data,
    output logic [LANES-1:0]             out_mask,
    output logic [beat_w(N, LANES)-1:0]  out_beat,
    output logic                         out_last,
`ifdef GF_COL_PARITY_EN
    output logic [LANES-1:0]             out_parity,
`endif
    output logic                         busy
);

    localparam int NBEATS = nbeats(N, LANES);
    localparam int BW     = beat_w(N, LANES);

    state_e             state_q, state_d;
    logic [M-1:0]       acc, src, acc_step;
    logic [M-1:0]       prod [LANES];
    logic [BW-1:0]      beat_d;
    logic [LANES-1:0]   mask_d;
    logic [LANES*M-1:0] data_d;
    logic               fire, load;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == RUN;
    assign busy      = state_q == RUN;
    assign fire      = out_valid & out_ready;
    assign load      = (in_valid & in_ready) | (fire & !out_last);

    // The lanes multiply the fresh input on accept, the running accumulator afterwards.
    assign src = in_ready ? in_b : acc;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        gf_const_alpha_mult #(.M(M), .POLY(POLY), .E(STRIDE * (j + 1))) u_lane (
            .x(src),
            .y(prod[j])
        );
    end

    gf_const_alpha_mult #(.M(M), .POLY(POLY), .E(STRIDE * LANES)) u_step (
        .x(src),
        .y(acc_step)
    );

    always_comb begin
        beat_d = in_ready ? '0 : out_beat + 1'b1;
        mask_d = '0;
        data_d = '0;
        for (int j = 0; j < LANES; j++) begin
            mask_d[j]          = int'(beat_d) * LANES + j + 1 <= N;
            data_d[j*M +: M]   = mask_d[j] ? prod[j] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && in_valid)
            state_d = RUN;
        if (state_q == RUN && fire && out_last)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

`ifdef GF_COL_PARITY_EN
    logic [LANES-1:0] parity_d;
    always_comb begin
        parity_d = '0;
        for (int j = 0; j < LANES; j++)
            parity_d[j] = ^data_d[j*M +: M];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)       out_parity <= '0;
        else if (load) out_parity <= parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_mask <= '0;
            out_beat <= '0;
            out_last <= 1'b0;
            acc      <= '0;
        end else if (load) begin
            out_data <= data_d;
            out_mask <= mask_d;
            out_beat <= beat_d;
            out_last <= beat_d == BW'(NBEATS - 1);
            acc      <= acc_step;
        end
    end

endmodule

// File: tb/tb_gf_alpha_column_seq.sv
// tb_gf_alpha_column_seq: randomized stream checks against a GF(2^13) multiply model
module tb_gf_alpha_column_seq;

    logic        clk = 0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [12:0] in_b;
    logic [51:0] out_data;
    logic [3:0]  out_mask;
    logic [2:0]  out_beat;

    logic        in_valid6, in_ready6, out_valid6, out_ready6, out_last6, busy6;
    logic [12:0] in_b6;
    logic [51:0] out_data6;
    logic [3:0]  out_mask6;
    logic [1:0]  out_beat6;

`ifdef GF_COL_PARITY_EN
    logic [3:0] out_parity, out_parity6;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gf_alpha_column_seq #(.M(13), .POLY(13'h001B), .N(16), .LANES(4), .STRIDE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
        .out_beat(out_beat), .out_last(out_last),
`ifdef GF_COL_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy(busy)
    );

    gf_alpha_column_seq #(.M(13), .POLY(13'h001B), .N(6), .LANES(4), .STRIDE(1)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .in_b(in_b6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .out_mask(out_mask6),
        .out_beat(out_beat6), .out_last(out_last6),
`ifdef GF_COL_PARITY_EN
        .out_parity(out_parity6),
`endif
        .busy(busy6)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full polynomial multiply then reduce by x^13+x^4+x^3+x+1.
    function automatic logic [12:0] gmul(input logic [12:0] a, input logic [12:0] b);
        logic [25:0] p;
        p = '0;
        for (int i = 0; i < 13; i++)
            if (b[i]) p ^= 26'(a) << i;
        for (int i = 25; i >= 13; i--)
            if (p[i]) p ^= 26'h201B << (i - 13);
        return p[12:0];
    endfunction

    function automatic logic [12:0] apow(input int k);
        logic [12:0] r;
        r = 13'h1;
        for (int i = 0; i < k; i++) r = gmul(r, 13'h2);
        return r;
    endfunction

    task automatic check_beat(input logic [12:0] b, input int t);
        logic [12:0] exp;
        chk("valid", out_valid, 1);
        chk("busy", busy, 1);
        chk("in_ready_busy", in_ready, 0);
        chk("beat", out_beat, t);
        chk("last", out_last, t == 3);
        chk("mask", out_mask, 4'hF);
        for (int j = 0; j < 4; j++) begin
            exp = gmul(b, apow(t * 4 + j + 1));
            chk($sformatf("data b=%h t=%0d j=%0d", b, t, j), out_data[j*13 +: 13], exp);
`ifdef GF_COL_PARITY_EN
            chk("parity", out_parity[j], ^exp);
`endif
        end
    endtask

    task automatic stream(input logic [12:0] b, input int stall_at, input int stall_n,
                          input int abort_at, input bit hold, input logic [12:0] nb);
        int w;
        in_b = b;
        in_valid = 1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = hold;
        in_b = hold ? nb : 13'($urandom);
        for (int t = 0; t < 4; t++) begin
            if (t == abort_at) begin
                rst = 1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_data", out_data, 0);
                chk("rst_mask", out_mask, 0);
                chk("rst_beat", out_beat, 0);
                chk("rst_last", out_last, 0);
                chk("rst_busy", busy, 0);
                @(negedge clk);
                rst = 0;
                #1;
                chk("post_rst_ready", in_ready, 1);
                chk("post_rst_valid", out_valid, 0);
                return;
            end
            if (t == stall_at) begin
                out_ready = 0;
                for (int s = 0; s < stall_n; s++) begin
                    check_beat(b, t);
                    @(negedge clk);
                end
                out_ready = 1;
            end
            check_beat(b, t);
            @(negedge clk);
        end
        chk("end_valid", out_valid, 0);
        chk("end_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1;
        in_valid = 0; in_b = 0; out_ready = 1;
        in_valid6 = 0; in_b6 = 0; out_ready6 = 1;
        repeat (2) @(negedge clk);
        chk("reset_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_mask", out_mask, 0);
        chk("reset_beat", out_beat, 0);
        chk("reset_last", out_last, 0);
        chk("reset_busy", busy, 0);
`ifdef GF_COL_PARITY_EN
        chk("reset_parity", out_parity, 0);
`endif
        rst = 0;
        @(negedge clk);

        stream(13'h0001, -1, 0, -1, 0, 0);
        stream(13'h1000, -1, 0, -1, 0, 0);
        stream(13'h0000, -1, 0, -1, 0, 0);
        stream(13'($urandom), 1, 3, -1, 0, 0);

        in_b6 = 13'h0001;
        in_valid6 = 1;
        @(negedge clk);
        in_valid6 = 0;
        chk("n6_valid0", out_valid6, 1);
        chk("n6_beat0", out_beat6, 0);
        chk("n6_last0", out_last6, 0);
        chk("n6_mask0", out_mask6, 4'hF);
        chk("n6_data0", out_data6, {13'h0010, 13'h0008, 13'h0004, 13'h0002});
`ifdef GF_COL_PARITY_EN
        chk("n6_par0", out_parity6, 4'hF);
`endif
        @(negedge clk);
        chk("n6_beat1", out_beat6, 1);
        chk("n6_last1", out_last6, 1);
        chk("n6_mask1", out_mask6, 4'b0011);
        chk("n6_data1", out_data6, {13'h0, 13'h0, 13'h0040, 13'h0020});
`ifdef GF_COL_PARITY_EN
        chk("n6_par1", out_parity6, 4'b0011);
`endif
        @(negedge clk);
        chk("n6_idle_valid", out_valid6, 0);
        chk("n6_idle_ready", in_ready6, 1);

        stream(13'h0ABC, -1, 0, 2, 0, 0);
        stream(13'h0123, -1, 0, -1, 0, 0);

        stream(13'h0055, -1, 0, -1, 1, 13'h0777);
        stream(13'h0777, -1, 0, -1, 0, 0);

        for (int i = 0; i < 1000; i++)
            stream(13'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
